ks_addsub_pipe_32b: RTL
=======================

# ks_addsub_pipe_32b

Fully pipelined 32-bit Kogge-Stone adder/subtractor with valid/ready handshakes on both sides. Each prefix level is a register stage, so one operation is accepted per clock. The block is the clocked, bidirectional (add and subtract) arithmetic unit that feeds the FFT butterfly datapath. Subtraction uses inverted B with carry-in 1. A tag travels with each operation so downstream logic can match results to requests.

## Interface
- TAG_W, default 4: width of the sideband tag carried alongside each operation.
- i_clk  input  1  single clock; all state changes on its rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  upstream operation valid.
- o_ready  output  1  block can accept an operation this cycle.
- i_sub  input  1  0 = A+B, 1 = A−B.
- i_a  input  32  operand A.
- i_b  input  32  operand B.
- i_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  32  A±B modulo 2^32.
- o_cout  output  1  carry out of bit 31. For subtract, 1 = no borrow.
- o_ovf  output  1  two's-complement signed overflow.
- o_tag  output  TAG_W  tag of the operation on o_sum.

## Operation
- Transfer in: i_valid && o_ready at a rising edge. Transfer out: o_valid && i_ready at a rising edge.
- The pipeline has 7 register stages, R0..R6, each with its own valid bit.
  - R0 stores the per-bit generate g=a&b' and propagate p=a^b', where b'=i_b^{32{i_sub}}. It also stores c0=i_sub, the saved p vector, a[31], b'[31] and the tag.
  - R1..R5 are the prefix levels with spans 1, 2, 4, 8 and 16.
  - At level with span s, bit k≥s uses a black cell: G=Gk|(Pk&Gk−s), P=Pk&Pk−s. Bits k<s use a grey cell that folds in c0, giving group generate Gk|(Pk&carry_into_low_group). Their P passes through unchanged.
  - After R5, G[k] is the carry out of bit k, including c0.
  - R6 computes the outputs:
    - sum[0]=p[0]^c0 and sum[k]=p[k]^G[k−1].
    - cout=G[31].
    - ovf=G[31]^G[30].
    - The tag is passed through.
- Flow control uses one global enable: en = !o_valid || i_ready. When en=1, all stages advance together, including invalid bubbles. When en=0, every stage holds data and valid.
- o_ready = en. This is a combinational path from i_ready; it is permitted and documented.
- Ordering is strict FIFO. No operation is dropped, duplicated or reordered.
- The arithmetic is exact for every i_a, i_b and i_sub. For subtract, o_cout = (A ≥ B unsigned).

## Timing
- Latency: an operation captured into R0 at edge E appears in R6 at edge E+6. o_valid is high in the cycle after E+6, provided en=1 throughout.
- Throughput: one operation per cycle while i_ready=1.
- Stall: while o_valid=1 and i_ready=0:
  - o_sum, o_cout, o_ovf, o_tag and o_valid are held stable.
  - o_ready=0.
  - Upstream i_valid is ignored, with no capture.
- Bubbles are not collapsed. A stall freezes bubbles in place as well.
- Output-side handshake rules:
  - o_valid does not drop before a transfer.
  - Output data changes only on an edge where en=1.
- Reset: when i_rst_n=0 at an edge, all valid bits clear and all data registers clear to 0. In the following cycle:
  - o_valid=0, o_sum=0, o_cout=0, o_ovf=0, o_tag=0.
  - o_ready=1.
- Reset mid-stream discards all in-flight operations. No stale result appears after reset.
- Reset takes priority over any simultaneous transfer.
- Simultaneous input and output transfer in the same cycle is normal operation.
- An empty pipeline with i_valid=0 stays empty.

## Test plan
- Add wrap: i_sub=0, A=0x0000_0001, B=0xFFFF_FFFF, i_ready=1 → 7th edge after capture gives o_sum=0x0000_0000, o_cout=1, o_ovf=0.
- Subtract, signed overflow: i_sub=1, A=0x8000_0000, B=0x0000_0001 → o_sum=0x7FFF_FFFF, o_cout=1, o_ovf=1. Also A=0x7FFF_FFFF, i_sub=0, B=1 → o_sum=0x8000_0000, o_cout=0, o_ovf=1.
- Borrow: i_sub=1, A=5, B=7, tag=0x3 → o_sum=0xFFFF_FFFE, o_cout=0, o_ovf=0, o_tag=0x3.
- Streaming: 8 back-to-back ops with tags 0..7 (A=k, B=k<<16, mixed i_sub), i_ready=1 → o_valid high for 8 consecutive cycles, tags in order 0..7, each sum correct against the reference model. Then run 10^5 random ops with random i_valid/i_ready and check against the model.
- Backpressure: fill the pipeline, then hold i_ready=0 for 3 cycles → o_ready=0 and outputs frozen for those 3 cycles. After release, all results appear with no loss or duplication.
- Reset mid-stream: assert i_rst_n=0 for 1 cycle with 4 ops in flight → next cycle o_valid=0, o_sum=0, o_ready=1. None of the 4 ops ever emerges, and a fresh op afterwards completes in 7 cycles.

Source files
------------

// File: rtl/ks_addsub_pipe_32b.sv
// ks_addsub_pipe_32b: 7-stage pipelined Kogge-Stone 32-bit adder/subtractor with valid/ready flow control.
// Ports: i_clk/i_rst_n (sync active-low reset); i_valid/o_ready/i_sub/i_a/i_b/i_tag upstream;
//        o_valid/i_ready/o_sum/o_cout/o_ovf/o_tag downstream. o_ready is combinational from i_ready.
module ks_addsub_pipe_32b #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sub,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [TAG_W-1:0] o_tag
);
    logic [31:0]      g_q [6], g_d [6], pp_q [6], pp_d [6], p_q [6], p_d [6];
    logic [TAG_W-1:0] tag_q [6], tag_d [6];
    logic [5:0]       c0_q, c0_d, v_q, v_d;
    logic [31:0]      sum_q, sum_d, bx;
    logic             cout_q, cout_d, ovf_q, ovf_d, vo_q;
    logic [TAG_W-1:0] tago_q, tago_d;
    logic             en;

    assign en      = !vo_q || i_ready;
    assign o_ready = en;
    assign o_valid = vo_q;
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;
    assign o_tag   = tago_q;

    always_comb begin
        bx       = i_b ^ {32{i_sub}};
        p_d[0]   = i_a ^ bx;
        pp_d[0]  = p_d[0];
        // c0 is merged into bit 0's generate up front so that five prefix levels
        // deliver full carries (including c0) for all 32 bits, bit 31 included.
        g_d[0]   = (i_a & bx) | {31'b0, p_d[0][0] & i_sub};
        c0_d[0]  = i_sub;
        tag_d[0] = i_tag;
        v_d[0]   = i_valid;
        for (int l = 1; l < 6; l++) begin
            p_d[l]   = p_q[l-1];
            c0_d[l]  = c0_q[l-1];
            tag_d[l] = tag_q[l-1];
            v_d[l]   = v_q[l-1];
            for (int k = 0; k < 32; k++) begin
                // black cell for k >= span, grey cell folding c0 below it
                g_d[l][k]  = k >= (1 << (l - 1))
                           ? g_q[l-1][k] | (pp_q[l-1][k] & g_q[l-1][5'(k - (1 << (l - 1)))])
                           : g_q[l-1][k] | (pp_q[l-1][k] & c0_q[l-1]);
                pp_d[l][k] = k >= (1 << (l - 1))
                           ? pp_q[l-1][k] & pp_q[l-1][5'(k - (1 << (l - 1)))]
                           : pp_q[l-1][k];
            end
        end
        sum_d  = p_q[5] ^ {g_q[5][30:0], c0_q[5]};
        cout_d = g_q[5][31];
        ovf_d  = g_q[5][31] ^ g_q[5][30];
        tago_d = tag_q[5];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int l = 0; l < 6; l++) begin
                g_q[l]   <= '0;
                pp_q[l]  <= '0;
                p_q[l]   <= '0;
                tag_q[l] <= '0;
            end
            c0_q   <= '0;
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            tago_q <= '0;
            vo_q   <= 1'b0;
        end else if (en) begin
            g_q    <= g_d;
            pp_q   <= pp_d;
            p_q    <= p_d;
            tag_q  <= tag_d;
            c0_q   <= c0_d;
            v_q    <= v_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            tago_q <= tago_d;
            vo_q   <= v_q[5];
        end
    end
endmodule
